// File: rtl/hd_sample_sequencer.sv
// Per-sample sequencer for the hyperdimensional inference path: feature load,
// chunked encoding with flush framing and hypervector commit, then classification.
module hd_sample_sequencer #(
  parameter int FEA_ADDR_WIDTH = 8,
  parameter int LOAD_WORDS     = 32,
  parameter int CHUNK_CYCLES   = 32,
  parameter int FLUSH_CYCLES   = 2,
  parameter int NUM_CHUNKS     = 250,
  parameter int CHUNK_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset_in,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      feat_wr_valid,
  output logic                      feat_wr_en,
  output logic [FEA_ADDR_WIDTH-1:0] feat_wr_addr,
  output logic                      write_data_done,
  output logic                      cur_encode_done,
  input  logic                      enc_out_done,
  output logic                      acc_en,
  output logic                      hv_wr_en,
  output logic [CHUNK_WIDTH-1:0]    hv_wr_addr,
  output logic                      cls_start,
  input  logic                      cls_done,
  output logic                      busy,
  output logic                      sample_done,
  output logic                      seq_err
);

  localparam int CYC_W = $clog2(CHUNK_CYCLES + 1);
  localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [FEA_ADDR_WIDTH-1:0] LOAD_LAST  = FEA_ADDR_WIDTH'(LOAD_WORDS - 1);
  localparam logic [CYC_W-1:0]          CYC_LAST   = CYC_W'(CHUNK_CYCLES - 1);
  localparam logic [FL_W-1:0]           FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [CHUNK_WIDTH-1:0]    CHUNK_LAST = CHUNK_WIDTH'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ENCODE   = 3'd2,
    S_FLUSH    = 3'd3,
    S_CLASSIFY = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                      state_r, state_s;
  logic [FEA_ADDR_WIDTH-1:0]   load_cnt_r;
  logic [CYC_W-1:0]            cyc_cnt_r;
  logic [FL_W-1:0]             flush_cnt_r;
  logic [CHUNK_WIDTH-1:0]      chunk_r;
  logic                        cls_first_r;
  logic                        seq_err_r;
  logic                        wdd_r;

  logic launch_s, abort_s, load_last_s, cyc_last_s, flush_end_s, chunk_last_s, err_hit_s;

  // Condition decode shared by the FSM and the counters
  always_comb begin
    launch_s     = (state_r == S_IDLE) && start;
    abort_s      = (state_r != S_IDLE) && abort;
    load_last_s  = (state_r == S_LOAD) && feat_wr_valid && (load_cnt_r == LOAD_LAST);
    cyc_last_s   = (cyc_cnt_r == CYC_LAST);
    flush_end_s  = (flush_cnt_r == FLUSH_LAST);
    chunk_last_s = (chunk_r == CHUNK_LAST);
    // enc_out_done is only legitimate once the last chunk has reached its flush
    err_hit_s    = enc_out_done &&
                   ((state_r == S_ENCODE) || ((state_r == S_FLUSH) && !chunk_last_s));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:     if (start) state_s = S_LOAD; else state_s = S_IDLE;
        S_LOAD:     if (load_last_s) state_s = S_ENCODE; else state_s = S_LOAD;
        S_ENCODE:   if (cyc_last_s) state_s = S_FLUSH; else state_s = S_ENCODE;
        S_FLUSH: begin
          if (flush_end_s) begin
            if (chunk_last_s) state_s = S_CLASSIFY; else state_s = S_ENCODE;
          end else begin
            state_s = S_FLUSH;
          end
        end
        S_CLASSIFY: if (!cls_first_r && cls_done) state_s = S_DONE; else state_s = S_CLASSIFY;
        S_DONE:     state_s = S_IDLE;
        default:    state_s = S_IDLE;
      endcase
    end
  end

  // State register and the registered encoder-enable level
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_r <= S_IDLE;
      wdd_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      wdd_r   <= (state_s == S_ENCODE) || (state_s == S_FLUSH) ||
                 (state_s == S_CLASSIFY) || (state_s == S_DONE);
    end
  end

  // Load, cycle, flush and chunk counters plus the sticky sequencing error
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      load_cnt_r  <= {FEA_ADDR_WIDTH{1'b0}};
      cyc_cnt_r   <= {CYC_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
      chunk_r     <= {CHUNK_WIDTH{1'b0}};
      cls_first_r <= 1'b0;
      seq_err_r   <= 1'b0;
    end else if (launch_s) begin
      load_cnt_r  <= {FEA_ADDR_WIDTH{1'b0}};
      cyc_cnt_r   <= {CYC_W{1'b0}};
      flush_cnt_r <= {FL_W{1'b0}};
      chunk_r     <= {CHUNK_WIDTH{1'b0}};
      cls_first_r <= 1'b0;
      seq_err_r   <= 1'b0;
    end else begin
      if ((state_r == S_LOAD) && feat_wr_valid) begin
        load_cnt_r <= load_cnt_r + FEA_ADDR_WIDTH'(1);
      end else begin
        load_cnt_r <= load_cnt_r;
      end

      if (state_r == S_ENCODE) begin
        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
      end else if (state_r == S_FLUSH) begin
        cyc_cnt_r <= {CYC_W{1'b0}};
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end

      if ((state_r == S_FLUSH) && !flush_end_s) begin
        flush_cnt_r <= flush_cnt_r + FL_W'(1);
      end else begin
        flush_cnt_r <= {FL_W{1'b0}};
      end

      if ((state_r == S_FLUSH) && flush_end_s && !chunk_last_s && !abort_s) begin
        chunk_r <= chunk_r + CHUNK_WIDTH'(1);
      end else begin
        chunk_r <= chunk_r;
      end

      cls_first_r <= (state_r == S_FLUSH) && (state_s == S_CLASSIFY);

      if (err_hit_s) begin
        seq_err_r <= 1'b1;
      end else begin
        seq_err_r <= seq_err_r;
      end
    end
  end

  // Moore output decode; only the feature write strobe follows feat_wr_valid directly
  always_comb begin
    feat_wr_en      = feat_wr_valid && (state_r == S_LOAD);
    feat_wr_addr    = load_cnt_r;
    write_data_done = wdd_r;
    cur_encode_done = (state_r == S_FLUSH);
    acc_en          = (state_r == S_ENCODE);
    hv_wr_en        = (state_r == S_FLUSH) && (flush_cnt_r == {FL_W{1'b0}});
    hv_wr_addr      = chunk_r;
    cls_start       = (state_r == S_CLASSIFY) && cls_first_r;
    busy            = (state_r != S_IDLE);
    sample_done     = (state_r == S_DONE);
    seq_err         = seq_err_r;
  end

endmodule

// File: tb/tb_hd_sample_sequencer.sv
// Scoreboard bench for hd_sample_sequencer: a default-size instance for full samples,
// abort and error cases, and a small instance for the short-chunk configuration.
module tb_hd_sample_sequencer;

  localparam int LW  = 32;
  localparam int CC  = 32;
  localparam int FL  = 2;
  localparam int NCH = 250;
  localparam int PER = CC + FL;

  logic       clk = 1'b0;
  logic       reset_in = 1'b0;
  logic       start = 1'b0, abort = 1'b0, feat_wr_valid = 1'b0, enc_out_done = 1'b0, cls_done = 1'b0;
  logic       feat_wr_en, write_data_done, cur_encode_done, acc_en, hv_wr_en;
  logic       cls_start, busy, sample_done, seq_err;
  logic [7:0] feat_wr_addr, hv_wr_addr;

  logic       s_start = 1'b0, s_abort = 1'b0, s_valid = 1'b0, s_eod = 1'b0, s_cls_done = 1'b0;
  logic       s_feat_wr_en, s_wdd, s_ced, s_acc_en, s_hv_wr_en, s_cls_start, s_busy, s_sample_done, s_seq_err;
  logic [7:0] s_feat_wr_addr, s_hv_wr_addr;

  int checks_r = 0;
  int failures_r = 0;

  logic [7:0] exp_feat_q[$];
  logic [7:0] exp_hv_q[$];

  int cyc = 0, ced_run = 0, acc_run = 0, ced_bursts = 0, last_hv_cyc = 0;
  bit have_last_hv = 1'b0;

  hd_sample_sequencer #(.FEA_ADDR_WIDTH(8), .LOAD_WORDS(LW), .CHUNK_CYCLES(CC),
                        .FLUSH_CYCLES(FL), .NUM_CHUNKS(NCH), .CHUNK_WIDTH(8)) dut (
    .clk(clk), .reset_in(reset_in), .start(start), .abort(abort),
    .feat_wr_valid(feat_wr_valid), .feat_wr_en(feat_wr_en), .feat_wr_addr(feat_wr_addr),
    .write_data_done(write_data_done), .cur_encode_done(cur_encode_done),
    .enc_out_done(enc_out_done), .acc_en(acc_en), .hv_wr_en(hv_wr_en), .hv_wr_addr(hv_wr_addr),
    .cls_start(cls_start), .cls_done(cls_done), .busy(busy), .sample_done(sample_done),
    .seq_err(seq_err));

  hd_sample_sequencer #(.FEA_ADDR_WIDTH(8), .LOAD_WORDS(4), .CHUNK_CYCLES(4),
                        .FLUSH_CYCLES(1), .NUM_CHUNKS(2), .CHUNK_WIDTH(8)) dut_small (
    .clk(clk), .reset_in(reset_in), .start(s_start), .abort(s_abort),
    .feat_wr_valid(s_valid), .feat_wr_en(s_feat_wr_en), .feat_wr_addr(s_feat_wr_addr),
    .write_data_done(s_wdd), .cur_encode_done(s_ced),
    .enc_out_done(s_eod), .acc_en(s_acc_en), .hv_wr_en(s_hv_wr_en), .hv_wr_addr(s_hv_wr_addr),
    .cls_start(s_cls_start), .cls_done(s_cls_done), .busy(s_busy), .sample_done(s_sample_done),
    .seq_err(s_seq_err));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_r++;
    if (act !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({feat_wr_en, feat_wr_addr, write_data_done, cur_encode_done, acc_en,
                hv_wr_en, hv_wr_addr, cls_start, busy, sample_done, seq_err});
  endfunction

  // Scoreboard monitor: feature writes, hv commits, burst shapes, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (feat_wr_en) begin
      if (exp_feat_q.size() == 0) check_eq("feat_unexpected", 32'(feat_wr_addr), 32'hFFFF);
      else check_eq("feat_addr", 32'(feat_wr_addr), 32'(exp_feat_q.pop_front()));
    end
    if (hv_wr_en) begin
      if (exp_hv_q.size() == 0) check_eq("hv_unexpected", 32'(hv_wr_addr), 32'hFFFF);
      else check_eq("hv_addr", 32'(hv_wr_addr), 32'(exp_hv_q.pop_front()));
      if (have_last_hv) check_eq("hv_spacing", 32'(cyc - last_hv_cyc), 32'(PER));
      last_hv_cyc = cyc;
      have_last_hv = 1'b1;
    end
    if (cur_encode_done) begin
      if (ced_run == 0) check_eq("ced_with_acc", 32'(acc_en), 32'd0);
      ced_run++;
    end else if (ced_run != 0) begin
      check_eq("ced_burst_len", 32'(ced_run), 32'(FL));
      ced_run = 0;
      ced_bursts++;
    end
    if (acc_en) acc_run++;
    else if (acc_run != 0) begin
      check_eq("acc_run_len", 32'(acc_run), 32'(CC));
      acc_run = 0;
    end
  end

  task automatic run_sample(input bit gapped, input int abort_chunk, input int err_chunk);
    int  c;
    bit  seen;
    int  nch;
    nch = (abort_chunk >= 0) ? abort_chunk + 1 : NCH;
    for (int k = 0; k < nch; k++) exp_hv_q.push_back(8'(k));
    ced_bursts = 0;
    have_last_hv = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_seq_err_clr", 32'(seq_err), 32'd0);
    for (int i = 0; i < LW; i++) begin
      if (gapped) begin
        feat_wr_valid = 1'b0;
        tick();
      end
      feat_wr_valid = 1'b1;
      exp_feat_q.push_back(8'(i));
      check_eq("wdd_in_load", 32'(write_data_done), 32'd0);
      tick();
    end
    feat_wr_valid = 1'b0;
    check_eq("wdd_after_load", 32'(write_data_done), 32'd1);
    check_eq("acc_after_load", 32'(acc_en), 32'd1);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 9000) begin
      enc_out_done = (c == err_chunk * PER + 5);
      abort = (abort_chunk >= 0) && (c == abort_chunk * PER + CC + 1);
      tick();
      c++;
      enc_out_done = 1'b0;
      abort = 1'b0;
      if (err_chunk >= 0 && c == err_chunk * PER + 6)
        check_eq("seq_err_set", 32'(seq_err), 32'd1);
      if (abort_chunk >= 0 && c == abort_chunk * PER + PER) begin
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_wdd", 32'(write_data_done), 32'd0);
        check_eq("abort_ced", 32'(cur_encode_done), 32'd0);
        seen = 1'b1;
      end else if (cls_start) begin
        seen = 1'b1;
      end
    end
    if (abort_chunk >= 0) begin
      tick();
      check_eq("abort_bursts", 32'(ced_bursts), 32'(nch));
      check_eq("abort_hv_left", 32'(exp_hv_q.size()), 32'd0);
    end else begin
      check_eq("cls_start_cycle", 32'(c), 32'(NCH * PER));
      check_eq("cls_wdd", 32'(write_data_done), 32'd1);
      tick();
      check_eq("cls_start_once", 32'(cls_start), 32'd0);
      tick();
      tick();
      cls_done = 1'b1;
      check_eq("done_early", 32'(sample_done), 32'd0);
      tick();
      cls_done = 1'b0;
      check_eq("sample_done", 32'(sample_done), 32'd1);
      check_eq("done_busy", 32'(busy), 32'd1);
      tick();
      check_eq("done_pulse_end", 32'(sample_done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_wdd", 32'(write_data_done), 32'd0);
      check_eq("burst_count", 32'(ced_bursts), 32'(NCH));
      check_eq("hv_all_done", 32'(exp_hv_q.size()), 32'd0);
      check_eq("seq_err_end", 32'(seq_err), (err_chunk >= 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int hv_cnt, hv_c0, hv_c1, cls_c;
    logic [7:0] hv_a0, hv_a1;
    bit done;

    #2;
    check_eq("reset_outs", all_outs(), 32'd0);
    tick();
    reset_in = 1'b1;
    tick();
    check_eq("idle_outs", all_outs(), 32'd0);

    // Reset in the middle of a load
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      feat_wr_valid = 1'b1;
      exp_feat_q.push_back(8'(i));
      tick();
    end
    #1;
    reset_in = 1'b0;
    #1;
    check_eq("async_reset_outs", all_outs(), 32'd0);
    feat_wr_valid = 1'b0;
    tick();
    reset_in = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    feat_wr_valid = 1'b1;
    exp_feat_q.push_back(8'd0);
    check_eq("reload_addr0", 32'(feat_wr_addr), 32'd0);
    tick();
    feat_wr_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_load_idle", 32'(busy), 32'd0);

    run_sample(1'b0, -1, -1);
    run_sample(1'b1, 100, -1);
    run_sample(1'b0, -1, 200);

    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("seq_err_clears", 32'(seq_err), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("feat_q_empty", 32'(exp_feat_q.size()), 32'd0);

    // Short-chunk configuration
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    hv_cnt = 0; hv_c0 = 0; hv_c1 = 0; cls_c = -1; hv_a0 = 8'd0; hv_a1 = 8'd0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (s_hv_wr_en) begin
        if (hv_cnt == 0) begin hv_c0 = c; hv_a0 = s_hv_wr_addr; end
        else begin hv_c1 = c; hv_a1 = s_hv_wr_addr; end
        hv_cnt++;
      end
      if (s_cls_start) begin
        cls_c = c;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    check_eq("small_hv_count", 32'(hv_cnt), 32'd2);
    check_eq("small_hv_addr0", 32'(hv_a0), 32'd0);
    check_eq("small_hv_addr1", 32'(hv_a1), 32'd1);
    check_eq("small_hv_spacing", 32'(hv_c1 - hv_c0), 32'd5);
    check_eq("small_cls_after_hv", 32'(cls_c - hv_c1), 32'd1);
    tick();
    s_cls_done = 1'b1;
    tick();
    s_cls_done = 1'b0;
    check_eq("small_sample_done", 32'(s_sample_done), 32'd1);
    tick();
    check_eq("small_idle", 32'(s_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
